// File: rtl/litedram_port_arbiter_if.sv
// litedram_port_arbiter_if: bundles requester 0/1 pipelined Wishbone ports and the classic Wishbone DRAM user port; slave = arbiter view, master = requesters+DRAM view
interface litedram_port_arbiter_if;
  logic m0_cyc, m0_stb, m0_we, m0_stall, m0_ack, m0_err;
  logic [31:0] m0_adr, m0_dat_w, m0_dat_r;
  logic [3:0] m0_sel;
  logic m1_cyc, m1_stb, m1_we, m1_stall, m1_ack, m1_err;
  logic [31:0] m1_adr, m1_dat_w, m1_dat_r;
  logic [3:0] m1_sel;
  logic [23:0] s_adr;
  logic [127:0] s_dat_w, s_dat_r;
  logic [15:0] s_sel;
  logic s_cyc, s_stb, s_we, s_ack, s_err;
  modport slave (
    input m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel,
    output m0_dat_r, m0_stall, m0_ack, m0_err,
    input m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel,
    output m1_dat_r, m1_stall, m1_ack, m1_err,
    output s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we,
    input s_dat_r, s_ack, s_err
  );
  modport master (
    output m0_cyc, m0_stb, m0_we, m0_adr, m0_dat_w, m0_sel,
    input m0_dat_r, m0_stall, m0_ack, m0_err,
    output m1_cyc, m1_stb, m1_we, m1_adr, m1_dat_w, m1_sel,
    input m1_dat_r, m1_stall, m1_ack, m1_err,
    input s_adr, s_dat_w, s_sel, s_cyc, s_stb, s_we,
    output s_dat_r, s_ack, s_err
  );
endinterface

// File: rtl/litedram_port_arbiter.sv
// litedram_port_arbiter: round-robin 2-requester 32-bit Wishbone to 128-bit DRAM port arbiter (clk, rst, bus.slave: m0_*/m1_* requesters, s_* DRAM); optional BUSY timeout via LITEDRAM_ARB_TIMEOUT_EN
module litedram_port_arbiter #(
  parameter int TIMEOUT_CYCLES = 1024
) (
  input logic clk,
  input logic rst,
  litedram_port_arbiter_if.slave bus
);
  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;
  state_t r_state, w_next;
  logic w_req0, w_req1, w_any, w_gnt, w_gcyc, w_to, w_done, w_busy, w_resp, w_hit;
  logic r_last, r_gnt, r_we, r_err, r_abn;
  logic [25:0] r_adr;
  logic [31:0] r_dat, r_dat_r0, r_dat_r1, w_word;
  logic [3:0] r_sel;
  logic [1:0] w_lane;
  assign w_req0 = bus.m0_cyc & bus.m0_stb;
  assign w_req1 = bus.m1_cyc & bus.m1_stb;
  assign w_any = w_req0 | w_req1;
  assign w_gnt = (w_req0 & w_req1) ? ~r_last : w_req1;
  assign w_gcyc = r_gnt ? bus.m1_cyc : bus.m0_cyc;
  assign w_lane = r_adr[1:0];
  assign w_word = bus.s_dat_r[{w_lane, 5'b0} +: 32];
  assign w_hit = bus.s_ack | bus.s_err;
`ifdef LITEDRAM_ARB_TIMEOUT_EN
  localparam int CW = TIMEOUT_CYCLES > 1 ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] TO_LAST = CW'(TIMEOUT_CYCLES - 1);
  logic [CW-1:0] r_cnt;
  always_ff @(posedge clk)
    r_cnt <= (rst || r_state != BUSY) ? '0 : r_cnt + 1'b1;
  assign w_to = r_state == BUSY && r_cnt == TO_LAST;
`else
  assign w_to = 1'b0;
`endif
  assign w_done = w_hit | w_to;
  always_comb begin
    w_next = r_state;
    w_next = r_state == IDLE ? (w_any ? BUSY : IDLE) :
             r_state == BUSY ? (w_done ? RESP : BUSY) : IDLE;
  end
  assign w_busy = r_state == BUSY && !rst;
  assign w_resp = r_state == RESP && !rst && !r_abn;
  assign bus.s_cyc = w_busy;
  assign bus.s_stb = w_busy;
  assign bus.s_we = w_busy & r_we;
  assign bus.s_adr = r_adr[25:2];
  assign bus.s_dat_w = {4{r_dat}};
  assign bus.s_sel = 16'(r_sel) << {w_lane, 2'b00};
  assign bus.m0_ack = w_resp & !r_gnt & !r_err;
  assign bus.m0_err = w_resp & !r_gnt & r_err;
  assign bus.m1_ack = w_resp & r_gnt & !r_err;
  assign bus.m1_err = w_resp & r_gnt & r_err;
  assign bus.m0_stall = !rst && (r_state != IDLE || (w_any && w_gnt));
  assign bus.m1_stall = !rst && (r_state != IDLE || (w_any && !w_gnt));
  assign bus.m0_dat_r = r_dat_r0;
  assign bus.m1_dat_r = r_dat_r1;
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_last <= 1'b1;
      r_gnt <= 1'b0;
      r_we <= 1'b0;
      r_err <= 1'b0;
      r_abn <= 1'b0;
      r_adr <= '0;
      r_dat <= '0;
      r_sel <= '0;
      r_dat_r0 <= '0;
      r_dat_r1 <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == IDLE && w_any) begin
        r_gnt <= w_gnt;
        r_last <= w_gnt;
        r_adr <= w_gnt ? bus.m1_adr[25:0] : bus.m0_adr[25:0];
        r_dat <= w_gnt ? bus.m1_dat_w : bus.m0_dat_w;
        r_sel <= w_gnt ? bus.m1_sel : bus.m0_sel;
        r_we <= w_gnt ? bus.m1_we : bus.m0_we;
        r_err <= 1'b0;
        r_abn <= 1'b0;
      end
      if (r_state == BUSY) begin
        if (!w_gcyc) r_abn <= 1'b1;
        if (w_done) r_err <= bus.s_err | ~bus.s_ack;
        if (w_hit && r_gnt) r_dat_r1 <= w_word;
        if (w_hit && !r_gnt) r_dat_r0 <= w_word;
      end
    end
  end
endmodule

// File: doc/litedram_port_arbiter.md
LITEDRAM_PORT_ARBITER -- requirements
Module: litedram_port_arbiter

Interface
REQ-001 Parameter TIMEOUT_CYCLES, default 1024: maximum cycles a DRAM access may stay outstanding before it is aborted.
REQ-002 Port clk, input, 1: single clock for all logic.
REQ-003 Port rst, input, 1: synchronous, active-high reset.
REQ-004 Ports m0_cyc, m0_stb, m0_we, input, 1 each: requester 0 pipelined Wishbone controls.
REQ-005 Ports m0_adr input 32, m0_dat_w input 32, m0_sel input 4: requester 0 word address, write data and byte enables.
REQ-006 Ports m0_dat_r output 32, m0_stall/m0_ack/m0_err output 1 each: requester 0 responses.
REQ-007 Ports m1_* output the same set as m0_*: requester 1.
REQ-008 Ports s_adr output 24, s_dat_w output 128, s_sel output 16, s_cyc/s_stb/s_we output 1 each: classic Wishbone DRAM user port.
REQ-009 Ports s_dat_r input 128, s_ack/s_err input 1 each: DRAM user port responses.

Function
REQ-010 FSM states: IDLE, BUSY, RESP; exactly one access outstanding at any time.
REQ-011 Request: mX_req = mX_cyc & mX_stb; stb without cyc is ignored.
REQ-012 IDLE, one request: that requester is granted; both requests: round-robin grants the requester not served last.
REQ-013 IDLE stall: the losing requester's stall = 1 and the granted requester's stall = 0 in the acceptance cycle; in BUSY and RESP both stalls = 1.
REQ-014 Acceptance in IDLE registers adr, dat_w, sel, we and the grant index, moves to BUSY, and updates the last-served pointer.
REQ-015 Address mapping: s_adr = adr[25:2]; lane = adr[1:0].
REQ-016 Write steering: s_dat_w = dat_w replicated 4 times; s_sel = sel shifted to bits [4*lane+3:4*lane], all other bits 0.
REQ-017 BUSY: s_cyc = s_stb = 1 and held stable until s_ack or s_err is seen.
REQ-018 On s_ack or s_err: mX_dat_r <= s_dat_r[32*lane+31:32*lane], the matching error flag is registered, s_cyc/s_stb drop in the next cycle, and the FSM moves to RESP.
REQ-019 RESP: the granted requester sees ack or err (exclusive) for exactly one cycle, then the FSM returns to IDLE.
REQ-020 Latency: acceptance at cycle N gives s_stb high at N+1, and response to the requester at K+1, where K is the s_ack cycle; minimum 3 cycles.
REQ-021 Abandon: if the granted requester drops cyc during BUSY, the DRAM access completes and the RESP ack/err is suppressed.
REQ-022 The non-granted requester's ack and err stay 0 at all times.
REQ-023 mX_dat_r holds its last value outside RESP.
REQ-024 A new request may be accepted in the IDLE cycle immediately after RESP, so back-to-back throughput is one access per 3+ cycles.

Reset
REQ-025 While rst = 1, the FSM forces IDLE; s_cyc, s_stb, s_we, all acks and all errs = 0; both stalls = 0; the last-served pointer = 1, so m0 wins the first tie.
REQ-026 Reset during BUSY or RESP drops s_cyc/s_stb in the next cycle with no requester response.
REQ-027 mX_dat_r, s_adr, s_dat_w and s_sel reset to 0.

Configuration
REQ-028 Macro LITEDRAM_ARB_TIMEOUT_EN defined: a BUSY cycle counter runs; when it reaches TIMEOUT_CYCLES without s_ack/s_err, s_cyc/s_stb drop, RESP signals err, and a late s_ack is ignored.
REQ-029 Macro absent: no counter is built and BUSY waits indefinitely.

Verification
REQ-030 m0 read adr 0x0000_0006, s_dat_r word2 = 0xDEADBEEF, s_ack after 5 cycles -> s_adr = 0x000001, m0_dat_r = 0xDEADBEEF with m0_ack one cycle.
REQ-031 m1 write adr 0x0000_0003, sel 0x3, data 0x12345678 -> s_sel = 0x3000, s_dat_w = 4x 0x12345678, s_we = 1, m1_ack one cycle.
REQ-032 m0 and m1 request simultaneously after reset, held continuously -> grant order m0, m1, m0, m1; no dropped or duplicated acks.
REQ-033 s_err asserted for an m1 access -> m1_err for one cycle, m1_ack = 0, FSM back to IDLE.
REQ-034 With LITEDRAM_ARB_TIMEOUT_EN and TIMEOUT_CYCLES = 16, s_ack is never asserted -> s_stb drops after 16 BUSY cycles and m0_err pulses; without the macro, s_stb stays high.
REQ-035 rst pulsed during BUSY -> s_cyc = 0 next cycle, no ack or err, and the next request is served normally.
